writeback_stage: RTL

//   Final pipeline stage; produces the register-file write port (enable, address, data) consumed by the decode stage.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/writeback_stage.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared defaults and state encoding for the CPU writeback stage.
package cpu_pkg;

  localparam int unsigned WB_DATA_W  = 16;
  localparam int unsigned WB_ADDR_W  = 4;
  localparam int unsigned WB_TIMEOUT = 15;
  localparam int unsigned WB_CNT_W   = 16;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

endpackage : cpu_pkg

// File: rtl/writeback_stage.sv
// Writeback stage: drives the register-file write port from ALU results or
// returned load data, exposes the write as a bypass, and counts retired writes.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = WB_DATA_W,
  parameter int unsigned ADDR_W  = WB_ADDR_W,
  parameter int unsigned TIMEOUT = WB_TIMEOUT,
  parameter int unsigned CNT_W   = WB_CNT_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic [ADDR_W-1:0] i_dest,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_stall,
  output logic              o_write_en,
  output logic [ADDR_W-1:0] o_write_add,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_fwd_valid,
  output logic [ADDR_W-1:0] o_fwd_add,
  output logic [DATA_W-1:0] o_fwd_data,
  output logic              o_mem_error,
  output logic [CNT_W-1:0]  o_retire_count
);

  // Counter must be able to hold the value TIMEOUT itself.
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  wb_state_t         state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state, write-port and bookkeeping logic.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    dest_d  = dest_q;
    we_d    = 1'b0;
    add_d   = '0;
    data_d  = '0;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (i_valid && i_reg_write) begin
          if (i_mem_to_reg) begin
            state_d = LOAD_WAIT;
            dest_d  = i_dest;
            tmo_d   = '0;
          end else begin
            we_d   = 1'b1;
            add_d  = i_dest;
            data_d = i_alu_result;
          end
        end
      end
      LOAD_WAIT: begin
        // Returning data takes priority over the timeout check.
        if (i_mem_rvalid) begin
          we_d    = 1'b1;
          add_d   = dest_q;
          data_d  = i_mem_rdata;
          state_d = IDLE;
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (we_d) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers; reset aborts any pending load.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      dest_q  <= '0;
      we_q    <= 1'b0;
      add_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      dest_q  <= dest_d;
      we_q    <= we_d;
      add_q   <= add_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_stall        = (state_q == LOAD_WAIT);
  assign o_write_en     = we_q;
  assign o_write_add    = add_q;
  assign o_write_data   = data_q;
  assign o_fwd_valid    = we_q;
  assign o_fwd_add      = add_q;
  assign o_fwd_data     = data_q;
  assign o_mem_error    = err_q;
  assign o_retire_count = cnt_q;

endmodule : writeback_stage
